// File: rtl/axi_txn_pkg.sv
// Shared types and constants for the AXI transaction decoder.
// Holds the controller state encoding, AXI burst/response codes and the fixed sideband values.
package axi_txn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_DATA,
        WR_RESP,
        RD_ISSUE,
        RD_DATA
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] DEFAULT_LOCK  = 2'b00;
    localparam logic [1:0] DEFAULT_CACHE = 2'b00;
    localparam logic [2:0] DEFAULT_PROT  = 3'b000;

    function automatic logic is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_txn_wbuf.sv
// One-entry write-beat holding stage between the write-data stream and the AXI master.
// A retiring beat and a new beat may swap in the same cycle, so a full stage never forces a bubble.
module axi_txn_wbuf #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_strb,
    input  logic                    ack,
    output logic                    load,
    output logic                    retire,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [DATA_WIDTH/8-1:0] out_strb
);

    logic full;

    // An ack against an empty stage has nothing to retire and is ignored.
    assign retire   = ack && full;
    assign in_ready = !full || ack;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            out_data <= '0;
            out_strb <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full     <= 1'b1;
            out_data <= in_data;
            out_strb <= in_strb;
        end else if (retire) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_txn_decoder.sv
// Single-outstanding transaction decoder in front of the AXI4 master: issues one command,
// streams write beats through a holding stage, and republishes write/read responses.
module axi_txn_decoder
    import axi_txn_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    AClk,
    input  logic                    ARst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rw,
    input  logic [3:0]              cmd_id,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_burst,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,
    output logic [3:0]              TXN_ID_W_d,
    output logic [ADDR_WIDTH-1:0]   awaddr_d,
    output logic [7:0]              awlen_d,
    output logic [2:0]              awsize_d,
    output logic [1:0]              awburst_d,
    output logic [1:0]              awlock_d,
    output logic [1:0]              awcache_d,
    output logic [2:0]              awprot_d,
    output logic                    wr_trn_en,
    output logic [DATA_WIDTH-1:0]   wdata_d,
    output logic [DATA_WIDTH/8-1:0] wstrb_d,
    input  logic                    w_beat_ack,
    input  logic [1:0]              bresp_d,
    input  logic [3:0]              bid_d,
    input  logic                    wr_rsp_en_d,
    output logic [3:0]              TXN_ID_R_d,
    output logic [ADDR_WIDTH-1:0]   araddr_d,
    output logic [7:0]              arlen_d,
    output logic [2:0]              arsize_d,
    output logic [1:0]              arburst_d,
    output logic [1:0]              arlock_d,
    output logic [1:0]              arcache_d,
    output logic [2:0]              arprot_d,
    output logic                    rd_trn_en,
    input  logic [DATA_WIDTH-1:0]   rdata_d,
    input  logic [1:0]              rresp_d,
    input  logic [7:0]              rid_d,
    input  logic                    rd_rsp_en_d,
    input  logic                    r_last_d,
    output logic                    rsp_valid,
    output logic                    rsp_is_wr,
    output logic [7:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_last,
    output logic                    busy,
    output logic                    timeout_flag,
    output logic [15:0]             err_cnt
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    state_t state, next_state;
    logic [8:0] load_cnt, ack_cnt, beats_total;
    logic [WDOG_W-1:0] wdog_cnt;
    logic accept_cmd, wr_gate, buf_in_valid, buf_in_ready, buf_ack, buf_load, buf_retire;
    logic last_ack, wr_rsp_fire, rd_rsp_fire, activity, wait_state, timeout_hit;

    assign beats_total  = {1'b0, awlen_d} + 9'd1;
    assign accept_cmd   = (state == IDLE) && cmd_valid && cmd_ready;
    assign wr_gate      = (state == WR_DATA) && (load_cnt != beats_total);
    assign buf_in_valid = wd_valid && wr_gate;
    assign buf_ack      = w_beat_ack && (state == WR_DATA);
    assign wd_ready     = wr_gate && buf_in_ready;
    assign last_ack     = buf_retire && ((ack_cnt + 9'd1) == beats_total);
    assign wr_rsp_fire  = (state == WR_RESP) && wr_rsp_en_d;
    assign rd_rsp_fire  = (state == RD_DATA) && rd_rsp_en_d;
    assign activity     = buf_load || buf_retire || wr_rsp_fire || rd_rsp_fire;
    assign wait_state   = (state == WR_DATA) || (state == WR_RESP) || (state == RD_DATA);
    assign timeout_hit  = wait_state && !activity && (wdog_cnt == WDOG_LAST);

    assign wr_trn_en = (state == WR_ISSUE);
    assign rd_trn_en = (state == RD_ISSUE);
    assign busy      = (state != IDLE);

    assign awlock_d  = DEFAULT_LOCK;
    assign awcache_d = DEFAULT_CACHE;
    assign awprot_d  = DEFAULT_PROT;
    assign arlock_d  = DEFAULT_LOCK;
    assign arcache_d = DEFAULT_CACHE;
    assign arprot_d  = DEFAULT_PROT;

    axi_txn_wbuf #(.DATA_WIDTH(DATA_WIDTH)) u_wbuf (
        .clk      (AClk),
        .rst_n    (ARst),
        .flush    (timeout_hit),
        .in_valid (buf_in_valid),
        .in_ready (buf_in_ready),
        .in_data  (wd_data),
        .in_strb  (wd_strb),
        .ack      (buf_ack),
        .load     (buf_load),
        .retire   (buf_retire),
        .out_data (wdata_d),
        .out_strb (wstrb_d)
    );

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept_cmd) next_state = cmd_rw ? WR_ISSUE : RD_ISSUE;
            WR_ISSUE: next_state = WR_DATA;
            WR_DATA:  if (last_ack) next_state = WR_RESP;
            WR_RESP:  if (wr_rsp_fire) next_state = IDLE;
            RD_ISSUE: next_state = RD_DATA;
            RD_DATA:  if (rd_rsp_fire && r_last_d) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (timeout_hit) next_state = IDLE;
    end

    // Registered so cmd_ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) cmd_ready <= 1'b0;
        else       cmd_ready <= (next_state == IDLE);
    end

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            TXN_ID_W_d <= '0;
            awaddr_d   <= '0;
            awlen_d    <= '0;
            awsize_d   <= '0;
            awburst_d  <= '0;
            TXN_ID_R_d <= '0;
            araddr_d   <= '0;
            arlen_d    <= '0;
            arsize_d   <= '0;
            arburst_d  <= '0;
        end else if (accept_cmd) begin
            TXN_ID_W_d <= cmd_id;
            awaddr_d   <= cmd_addr;
            awlen_d    <= cmd_len;
            awsize_d   <= cmd_size;
            awburst_d  <= cmd_burst;
            TXN_ID_R_d <= cmd_id;
            araddr_d   <= cmd_addr;
            arlen_d    <= cmd_len;
            arsize_d   <= cmd_size;
            arburst_d  <= cmd_burst;
        end
    end

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            load_cnt <= '0;
            ack_cnt  <= '0;
        end else if (accept_cmd) begin
            load_cnt <= '0;
            ack_cnt  <= '0;
        end else begin
            if (buf_load)   load_cnt <= load_cnt + 9'd1;
            if (buf_retire) ack_cnt  <= ack_cnt + 9'd1;
        end
    end

    // Watchdog restarts on every state change and on any beat or response progress.
    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            wdog_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (next_state != state || activity) wdog_cnt <= '0;
            else if (wait_state)                 wdog_cnt <= wdog_cnt + 1'b1;
            if (timeout_hit) timeout_flag <= 1'b1;
        end
    end

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            rsp_valid <= 1'b0;
            rsp_is_wr <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_resp  <= '0;
            rsp_last  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            rsp_valid <= wr_rsp_fire || rd_rsp_fire;
            if (wr_rsp_fire) begin
                rsp_is_wr <= 1'b1;
                rsp_id    <= {4'b0, bid_d};
                rsp_data  <= '0;
                rsp_resp  <= bresp_d;
                rsp_last  <= 1'b1;
            end else if (rd_rsp_fire) begin
                rsp_is_wr <= 1'b0;
                rsp_id    <= rid_d;
                rsp_data  <= rdata_d;
                rsp_resp  <= rresp_d;
                rsp_last  <= r_last_d;
            end
            if (((wr_rsp_fire && is_error(bresp_d)) || (rd_rsp_fire && is_error(rresp_d)))
                && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_axi_txn_decoder.sv
// Directed self-checking bench for axi_txn_decoder; each task drives one scenario and checks inline.
module tb_axi_txn_decoder;
    import axi_txn_pkg::*;

    logic        AClk = 1'b0;
    logic        ARst;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic [3:0]  TXN_ID_W_d, TXN_ID_R_d;
    logic [31:0] awaddr_d, araddr_d;
    logic [7:0]  awlen_d, arlen_d;
    logic [2:0]  awsize_d, arsize_d, awprot_d, arprot_d;
    logic [1:0]  awburst_d, awlock_d, awcache_d, arburst_d, arlock_d, arcache_d;
    logic        wr_trn_en, rd_trn_en;
    logic [63:0] wdata_d;
    logic [7:0]  wstrb_d;
    logic        w_beat_ack;
    logic [1:0]  bresp_d;
    logic [3:0]  bid_d;
    logic        wr_rsp_en_d;
    logic [63:0] rdata_d;
    logic [1:0]  rresp_d;
    logic [7:0]  rid_d;
    logic        rd_rsp_en_d, r_last_d;
    logic        rsp_valid, rsp_is_wr, rsp_last;
    logic [7:0]  rsp_id;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        busy, timeout_flag;
    logic [15:0] err_cnt;

    int tests = 0;
    int failed = 0;

    always #5 AClk = ~AClk;

    axi_txn_decoder #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(1024)) dut (
        .AClk(AClk), .ARst(ARst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .TXN_ID_W_d(TXN_ID_W_d), .awaddr_d(awaddr_d), .awlen_d(awlen_d), .awsize_d(awsize_d),
        .awburst_d(awburst_d), .awlock_d(awlock_d), .awcache_d(awcache_d), .awprot_d(awprot_d),
        .wr_trn_en(wr_trn_en), .wdata_d(wdata_d), .wstrb_d(wstrb_d), .w_beat_ack(w_beat_ack),
        .bresp_d(bresp_d), .bid_d(bid_d), .wr_rsp_en_d(wr_rsp_en_d),
        .TXN_ID_R_d(TXN_ID_R_d), .araddr_d(araddr_d), .arlen_d(arlen_d), .arsize_d(arsize_d),
        .arburst_d(arburst_d), .arlock_d(arlock_d), .arcache_d(arcache_d), .arprot_d(arprot_d),
        .rd_trn_en(rd_trn_en), .rdata_d(rdata_d), .rresp_d(rresp_d), .rid_d(rid_d),
        .rd_rsp_en_d(rd_rsp_en_d), .r_last_d(r_last_d),
        .rsp_valid(rsp_valid), .rsp_is_wr(rsp_is_wr), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_last(rsp_last),
        .busy(busy), .timeout_flag(timeout_flag), .err_cnt(err_cnt)
    );

    // Presents one command for a single edge; returns at the negedge after acceptance.
    task automatic send_cmd(input logic rw, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len);
        @(negedge AClk);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_id = id; cmd_addr = addr; cmd_len = len;
        cmd_size = 3'd3; cmd_burst = BURST_INCR;
        @(negedge AClk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        ARst = 1'b0;
        cmd_valid = 0; cmd_rw = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; w_beat_ack = 0;
        bresp_d = 0; bid_d = 0; wr_rsp_en_d = 0;
        rdata_d = 0; rresp_d = 0; rid_d = 0; rd_rsp_en_d = 0; r_last_d = 0;
        #3;
        tests++; if (cmd_ready !== 1'b0) begin failed++; $display("[TB] FAIL reset_cmd_ready: got %0h expected 0", cmd_ready); end
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
        tests++; if (rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_rsp_valid: got %0h expected 0", rsp_valid); end
        tests++; if (err_cnt !== 16'h0) begin failed++; $display("[TB] FAIL reset_err_cnt: got %0h expected 0", err_cnt); end
        tests++; if (wdata_d !== 64'h0) begin failed++; $display("[TB] FAIL reset_wdata: got %0h expected 0", wdata_d); end
        repeat (2) @(negedge AClk);
        ARst = 1'b1;
        #1;
        tests++; if (cmd_ready !== 1'b0) begin failed++; $display("[TB] FAIL release_cmd_ready_early: got %0h expected 0", cmd_ready); end
        @(negedge AClk);
        tests++; if (cmd_ready !== 1'b1) begin failed++; $display("[TB] FAIL release_cmd_ready: got %0h expected 1", cmd_ready); end
    endtask

    task automatic test_write();
        int pulses = 0;
        send_cmd(1'b1, 4'd5, 32'h1000, 8'd3);
        pulses += int'(wr_trn_en);
        tests++; if (wr_trn_en !== 1'b1) begin failed++; $display("[TB] FAIL wr_trn_en: got %0h expected 1", wr_trn_en); end
        tests++; if (awaddr_d !== 32'h1000) begin failed++; $display("[TB] FAIL awaddr: got %0h expected 1000", awaddr_d); end
        tests++; if (awlen_d !== 8'd3) begin failed++; $display("[TB] FAIL awlen: got %0h expected 3", awlen_d); end
        tests++; if (TXN_ID_W_d !== 4'd5) begin failed++; $display("[TB] FAIL aw_id: got %0h expected 5", TXN_ID_W_d); end
        tests++; if (awsize_d !== 3'd3) begin failed++; $display("[TB] FAIL awsize: got %0h expected 3", awsize_d); end
        tests++; if (cmd_ready !== 1'b0) begin failed++; $display("[TB] FAIL wr_cmd_ready: got %0h expected 0", cmd_ready); end
        @(negedge AClk);
        pulses += int'(wr_trn_en);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                tests++; if (wdata_d !== 64'h11 * k) begin failed++; $display("[TB] FAIL wdata_beat%0d: got %0h expected %0h", k, wdata_d, 64'h11 * k); end
            end
            wd_valid = (k < 4); wd_data = 64'h11 * (k + 1); wd_strb = 8'hFF; w_beat_ack = (k > 0);
            #1;
            if (k < 4) begin
                tests++; if (wd_ready !== 1'b1) begin failed++; $display("[TB] FAIL wd_ready_beat%0d: got %0h expected 1", k, wd_ready); end
            end
            @(negedge AClk);
            pulses += int'(wr_trn_en);
        end
        wd_valid = 0; w_beat_ack = 0;
        tests++; if (wd_ready !== 1'b0) begin failed++; $display("[TB] FAIL wd_ready_resp: got %0h expected 0", wd_ready); end
        wr_rsp_en_d = 1; bresp_d = RESP_OKAY; bid_d = 4'd5;
        @(negedge AClk);
        wr_rsp_en_d = 0;
        tests++; if (rsp_valid !== 1'b1) begin failed++; $display("[TB] FAIL wr_rsp_valid: got %0h expected 1", rsp_valid); end
        tests++; if (rsp_is_wr !== 1'b1) begin failed++; $display("[TB] FAIL wr_rsp_is_wr: got %0h expected 1", rsp_is_wr); end
        tests++; if (rsp_id !== 8'h05) begin failed++; $display("[TB] FAIL wr_rsp_id: got %0h expected 5", rsp_id); end
        tests++; if (rsp_resp !== 2'b00) begin failed++; $display("[TB] FAIL wr_rsp_resp: got %0h expected 0", rsp_resp); end
        tests++; if (rsp_last !== 1'b1) begin failed++; $display("[TB] FAIL wr_rsp_last: got %0h expected 1", rsp_last); end
        tests++; if (cmd_ready !== 1'b1) begin failed++; $display("[TB] FAIL wr_done_cmd_ready: got %0h expected 1", cmd_ready); end
        tests++; if (pulses !== 1) begin failed++; $display("[TB] FAIL wr_trn_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_read();
        send_cmd(1'b0, 4'd9, 32'h2000, 8'd7);
        tests++; if (rd_trn_en !== 1'b1) begin failed++; $display("[TB] FAIL rd_trn_en: got %0h expected 1", rd_trn_en); end
        tests++; if (araddr_d !== 32'h2000) begin failed++; $display("[TB] FAIL araddr: got %0h expected 2000", araddr_d); end
        tests++; if (arlen_d !== 8'd7) begin failed++; $display("[TB] FAIL arlen: got %0h expected 7", arlen_d); end
        @(negedge AClk);
        tests++; if (rd_trn_en !== 1'b0) begin failed++; $display("[TB] FAIL rd_trn_en_pulse: got %0h expected 0", rd_trn_en); end
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) begin
                tests++; if (rsp_valid !== 1'b1) begin failed++; $display("[TB] FAIL rd_rsp_valid%0d: got %0h expected 1", j - 1, rsp_valid); end
                tests++; if (rsp_data !== 64'h100 + 64'(j - 1)) begin failed++; $display("[TB] FAIL rd_rsp_data%0d: got %0h expected %0h", j - 1, rsp_data, 64'h100 + 64'(j - 1)); end
                tests++; if (rsp_last !== (j == 8)) begin failed++; $display("[TB] FAIL rd_rsp_last%0d: got %0h expected %0h", j - 1, rsp_last, (j == 8)); end
                tests++; if (busy !== (j < 8)) begin failed++; $display("[TB] FAIL rd_busy%0d: got %0h expected %0h", j - 1, busy, (j < 8)); end
            end
            rd_rsp_en_d = (j < 8); rdata_d = 64'h100 + 64'(j); rid_d = 8'h09; rresp_d = RESP_OKAY; r_last_d = (j == 7);
            @(negedge AClk);
        end
        r_last_d = 0;
        tests++; if (rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL rd_rsp_after: got %0h expected 0", rsp_valid); end
        tests++; if (rsp_id !== 8'h09) begin failed++; $display("[TB] FAIL rd_rsp_id: got %0h expected 9", rsp_id); end
        tests++; if (rsp_is_wr !== 1'b0) begin failed++; $display("[TB] FAIL rd_rsp_is_wr: got %0h expected 0", rsp_is_wr); end
    endtask

    task automatic test_stall_and_errors();
        send_cmd(1'b1, 4'd3, 32'h3000, 8'd1);
        @(negedge AClk);
        wd_valid = 1; wd_data = 64'hA1; w_beat_ack = 0;
        @(negedge AClk);
        wd_data = 64'hA2;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (wd_ready !== 1'b0) begin failed++; $display("[TB] FAIL stall_wd_ready%0d: got %0h expected 0", i, wd_ready); end
            tests++; if (wdata_d !== 64'hA1) begin failed++; $display("[TB] FAIL stall_wdata%0d: got %0h expected a1", i, wdata_d); end
            @(negedge AClk);
        end
        w_beat_ack = 1;
        #1;
        tests++; if (wd_ready !== 1'b1) begin failed++; $display("[TB] FAIL swap_wd_ready: got %0h expected 1", wd_ready); end
        @(negedge AClk);
        tests++; if (wdata_d !== 64'hA2) begin failed++; $display("[TB] FAIL swap_wdata: got %0h expected a2", wdata_d); end
        wd_valid = 0;
        @(negedge AClk);
        w_beat_ack = 0;
        tests++; if (busy !== 1'b1) begin failed++; $display("[TB] FAIL stall_resp_busy: got %0h expected 1", busy); end
        tests++; if (wd_ready !== 1'b0) begin failed++; $display("[TB] FAIL stall_resp_wd_ready: got %0h expected 0", wd_ready); end
        wr_rsp_en_d = 1; bresp_d = RESP_SLVERR; bid_d = 4'd3;
        @(negedge AClk);
        wr_rsp_en_d = 0;
        tests++; if (rsp_resp !== 2'b10) begin failed++; $display("[TB] FAIL slverr_resp: got %0h expected 2", rsp_resp); end
        tests++; if (err_cnt !== 16'd1) begin failed++; $display("[TB] FAIL err_cnt_1: got %0h expected 1", err_cnt); end
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL stall_done_busy: got %0h expected 0", busy); end
        send_cmd(1'b0, 4'd4, 32'h4000, 8'd0);
        @(negedge AClk);
        rd_rsp_en_d = 1; rresp_d = RESP_DECERR; r_last_d = 1; rid_d = 8'h84; rdata_d = 64'hDEAD;
        @(negedge AClk);
        rd_rsp_en_d = 0; r_last_d = 0;
        tests++; if (rsp_resp !== 2'b11) begin failed++; $display("[TB] FAIL decerr_resp: got %0h expected 3", rsp_resp); end
        tests++; if (rsp_id !== 8'h84) begin failed++; $display("[TB] FAIL decerr_id: got %0h expected 84", rsp_id); end
        tests++; if (err_cnt !== 16'd2) begin failed++; $display("[TB] FAIL err_cnt_2: got %0h expected 2", err_cnt); end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        send_cmd(1'b1, 4'd6, 32'h5000, 8'd0);
        @(negedge AClk);
        wd_valid = 1; wd_data = 64'h55;
        @(negedge AClk);
        wd_valid = 0; w_beat_ack = 1;
        @(negedge AClk);
        w_beat_ack = 0;
        for (int i = 0; i < 1100 && busy; i++) begin
            cyc++;
            @(negedge AClk);
        end
        tests++; if (cyc !== 1024) begin failed++; $display("[TB] FAIL timeout_cycles: got %0d expected 1024", cyc); end
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL timeout_busy: got %0h expected 0", busy); end
        tests++; if (timeout_flag !== 1'b1) begin failed++; $display("[TB] FAIL timeout_flag: got %0h expected 1", timeout_flag); end
        tests++; if (cmd_ready !== 1'b1) begin failed++; $display("[TB] FAIL timeout_cmd_ready: got %0h expected 1", cmd_ready); end
        send_cmd(1'b0, 4'd7, 32'h6000, 8'd0);
        tests++; if (rd_trn_en !== 1'b1) begin failed++; $display("[TB] FAIL post_timeout_rd_trn: got %0h expected 1", rd_trn_en); end
        @(negedge AClk);
        rd_rsp_en_d = 1; rresp_d = RESP_OKAY; r_last_d = 1; rid_d = 8'h07;
        @(negedge AClk);
        rd_rsp_en_d = 0; r_last_d = 0;
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL post_timeout_busy: got %0h expected 0", busy); end
        tests++; if (timeout_flag !== 1'b1) begin failed++; $display("[TB] FAIL timeout_sticky: got %0h expected 1", timeout_flag); end
        tests++; if (err_cnt !== 16'd2) begin failed++; $display("[TB] FAIL post_timeout_err: got %0h expected 2", err_cnt); end
    endtask

    task automatic test_err_saturate();
        send_cmd(1'b0, 4'd1, 32'h7000, 8'd255);
        @(negedge AClk);
        rd_rsp_en_d = 1; rresp_d = RESP_DECERR; r_last_d = 0; rid_d = 8'h01;
        repeat (100) @(negedge AClk);
        tests++; if (err_cnt !== 16'd102) begin failed++; $display("[TB] FAIL err_cnt_102: got %0d expected 102", err_cnt); end
        repeat (65440) @(negedge AClk);
        tests++; if (err_cnt !== 16'hFFFF) begin failed++; $display("[TB] FAIL err_cnt_sat: got %0h expected ffff", err_cnt); end
        tests++; if (busy !== 1'b1) begin failed++; $display("[TB] FAIL sat_busy: got %0h expected 1", busy); end
        r_last_d = 1;
        @(negedge AClk);
        rd_rsp_en_d = 0; r_last_d = 0;
        tests++; if (err_cnt !== 16'hFFFF) begin failed++; $display("[TB] FAIL err_cnt_hold: got %0h expected ffff", err_cnt); end
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL sat_done_busy: got %0h expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        send_cmd(1'b1, 4'd2, 32'h8000, 8'd3);
        @(negedge AClk);
        wd_valid = 1; wd_data = 64'h71; wd_strb = 8'hFF;
        @(negedge AClk);
        wd_data = 64'h72; w_beat_ack = 1;
        @(negedge AClk);
        tests++; if (wdata_d !== 64'h72) begin failed++; $display("[TB] FAIL mid_beat2: got %0h expected 72", wdata_d); end
        #2 ARst = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL mid_rst_busy: got %0h expected 0", busy); end
        tests++; if (wdata_d !== 64'h0) begin failed++; $display("[TB] FAIL mid_rst_wdata: got %0h expected 0", wdata_d); end
        tests++; if (wstrb_d !== 8'h0) begin failed++; $display("[TB] FAIL mid_rst_wstrb: got %0h expected 0", wstrb_d); end
        tests++; if (awaddr_d !== 32'h0) begin failed++; $display("[TB] FAIL mid_rst_awaddr: got %0h expected 0", awaddr_d); end
        tests++; if (wd_ready !== 1'b0) begin failed++; $display("[TB] FAIL mid_rst_wd_ready: got %0h expected 0", wd_ready); end
        tests++; if (err_cnt !== 16'h0) begin failed++; $display("[TB] FAIL mid_rst_err: got %0h expected 0", err_cnt); end
        tests++; if (timeout_flag !== 1'b0) begin failed++; $display("[TB] FAIL mid_rst_timeout: got %0h expected 0", timeout_flag); end
        tests++; if (cmd_ready !== 1'b0) begin failed++; $display("[TB] FAIL mid_rst_cmd_ready: got %0h expected 0", cmd_ready); end
        wd_valid = 0; w_beat_ack = 0;
        @(negedge AClk);
        ARst = 1'b1;
        @(negedge AClk);
        tests++; if (cmd_ready !== 1'b1) begin failed++; $display("[TB] FAIL after_rst_cmd_ready: got %0h expected 1", cmd_ready); end
        send_cmd(1'b1, 4'd1, 32'h9000, 8'd0);
        @(negedge AClk);
        tests++; if (wd_ready !== 1'b1) begin failed++; $display("[TB] FAIL after_rst_empty: got %0h expected 1", wd_ready); end
        wd_valid = 1; wd_data = 64'h99;
        @(negedge AClk);
        wd_valid = 0; w_beat_ack = 1;
        tests++; if (wdata_d !== 64'h99) begin failed++; $display("[TB] FAIL after_rst_wdata: got %0h expected 99", wdata_d); end
        @(negedge AClk);
        w_beat_ack = 0; wr_rsp_en_d = 1; bresp_d = RESP_OKAY; bid_d = 4'd1;
        @(negedge AClk);
        wr_rsp_en_d = 0;
        tests++; if (rsp_valid !== 1'b1) begin failed++; $display("[TB] FAIL after_rst_rsp: got %0h expected 1", rsp_valid); end
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL after_rst_busy: got %0h expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stall_and_errors();
        test_timeout();
        test_err_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
